// File: rtl/uart_tx_serializer.sv
// UART transmitter: serialises loadData[7:0] as start, 8 data bits LSB first, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and stop.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] loadData,
    input  logic        byte_ready,
    output logic        tx_busy,
    output logic        tx_serial,
    output logic        tx_done
);
    // state  | meaning
    // IDLE   | line high, waiting for byte_ready
    // START  | start bit (0) on the line
    // DATA   | data bit bit_idx on the line, LSB first
    // STOP   | stop bit (1) on the line
    // PARITY | even-parity bit on the line (parity builds only)
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        serial_d, busy_d, done_d;
    logic        bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_serial <= serial_d;
            tx_busy   <= busy_d;
            tx_done   <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = 16'd0;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = 1'b1;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (byte_ready) begin
                    state_d   = START;
                    shift_d   = loadData[7:0];
                    bit_idx_d = 3'd0;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
                else         baud_d  = baud_q + 16'd1;
            end
            DATA: begin
                if (bit_end) begin
                    // Rotate so the byte is whole again after bit 7 (parity reuses it).
                    shift_d   = {shift_q[0], shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
                else         baud_d  = baud_q + 16'd1;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_d = ^shift_d;
`endif
            default: serial_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer at CLKS_PER_BIT=4; parity cases need UART_TX_PARITY_EN.
module tb_uart_tx_serializer;
    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * C;

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         abort;
        int         len;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0, n_fail = 0, done_seen = 0, done_exp = 0;

    logic        clk = 1'b0, reset_n = 1'b0, byte_ready = 1'b0;
    logic [31:0] loadData = 32'd0;
    logic        tx_busy, tx_serial, tx_done;

    uart_tx_serializer #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .reset_n(reset_n), .loadData(loadData), .byte_ready(byte_ready),
        .tx_busy(tx_busy), .tx_serial(tx_serial), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void push_exp(logic [7:0] d, logic p, bit ab, int len, int gap);
        exp_t e;
        e.data = d; e.par = p; e.abort = ab; e.len = len; e.gap = gap;
        sb.push_back(e);
        if (!ab) done_exp++;
    endfunction

    // Monitor: records the line while busy, scores each frame when busy drops
    initial begin : monitor
        int samp[64];
        int cyc = 0, idle_cnt = 1000, gap = 0;
        bit active = 0, stable;
        logic [7:0] got;
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_done) done_seen++;
            if (tx_busy) begin
                if (!active) begin active = 1; cyc = 0; gap = idle_cnt; end
                if (cyc < 64) samp[cyc] = int'(tx_serial);
                cyc++;
                idle_cnt = 0;
            end else begin
                idle_cnt++;
                if (active) begin
                    active = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        if (e.abort) begin
                            check("abort_len", cyc, e.len);
                            check("abort_line_high", int'(tx_serial), 1);
                            check("abort_no_done", int'(tx_done), 0);
                        end else begin
                            check("frame_len", cyc, FRAME);
                            check("done_at_end", int'(tx_done), 1);
                            check("idle_line_high", int'(tx_serial), 1);
                            if (e.gap >= 0) check("frame_gap", gap, e.gap);
                            stable = 1;
                            for (int b = 0; b < NBITS; b++)
                                for (int s = 1; s < C; s++)
                                    if (samp[b*C+s] != samp[b*C]) stable = 0;
                            check("bit_stable", int'(stable), 1);
                            check("start_bit", samp[0], 0);
                            got = 8'd0;
                            for (int i = 0; i < 8; i++) got[i] = samp[(1+i)*C][0];
                            check("data_byte", int'(got), int'(e.data));
`ifdef UART_TX_PARITY_EN
                            check("parity_bit", samp[9*C], int'(e.par));
`endif
                            check("stop_bit", samp[(NBITS-1)*C], 1);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (tx_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(n < 200), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d, input logic [7:0] b, input logic p);
        push_exp(b, p, 0, 0, -1);
        @(negedge clk); loadData = d; byte_ready = 1'b1;
        @(negedge clk); byte_ready = 1'b0;
    endtask

    initial begin : stim
        int n;
        // Reset with a request present: must be discarded
        loadData = 32'h12; byte_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_serial", int'(tx_serial), 1);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_done", int'(tx_done), 0);
        reset_n = 1'b1; byte_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("req_in_reset_dropped", int'(tx_busy), 0);

        // Basic frame: A5 -> 1,0,1,0,0,1,0,1
        send(32'hDEAD_BEA5, 8'hA5, 1'b0);
        wait_idle();

        // Back-to-back with byte_ready held high
        push_exp(8'h55, 1'b0, 0, 0, -1);
        push_exp(8'hAA, 1'b0, 0, 0, 1);
        @(negedge clk); loadData = 32'h55; byte_ready = 1'b1;
        @(negedge clk); loadData = 32'hAA;
        n = 0;
        while (tx_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b_timeout", int'(n < 200), 1);
        @(negedge clk); byte_ready = 1'b0;
        check("b2b_second_started", int'(tx_busy), 1);
        wait_idle();

        // loadData changes during DATA
        push_exp(8'h0F, 1'b0, 0, 0, -1);
        @(negedge clk); loadData = 32'h0F; byte_ready = 1'b1;
        @(negedge clk); byte_ready = 1'b0;
        repeat (10) @(negedge clk);
        loadData = 32'hF0;
        wait_idle();

        // Request while busy is ignored
        send(32'h3C, 8'h3C, 1'b0);
        repeat (12) @(negedge clk);
        loadData = 32'hFF; byte_ready = 1'b1;
        @(negedge clk); byte_ready = 1'b0;
        wait_idle();
        check("no_second_frame", int'(tx_busy), 0);

        // Reset during data bit 3 aborts the frame
        push_exp(8'hC3, 1'b0, 1, 18, -1);
        @(negedge clk); loadData = 32'hC3; byte_ready = 1'b1;
        @(negedge clk); byte_ready = 1'b0;
        repeat (17) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(tx_busy), 0);
        check("abort_serial", int'(tx_serial), 1);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        send(32'h5A, 8'h5A, 1'b0);
        wait_idle();

`ifdef UART_TX_PARITY_EN
        send(32'h07, 8'h07, 1'b1);
        wait_idle();
        send(32'h03, 8'h03, 1'b0);
        wait_idle();
`endif

        check("done_pulses", done_seen, done_exp);
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port loadData, input, 32: store data captured by the load/store unit; only bits [7:0] are transmitted.
REQ-005 The block SHALL have port byte_ready, input, 1: transmit request from the load/store unit.
REQ-006 The block SHALL have port tx_busy, output, 1: high while a frame is in progress; the load/store unit holds off new requests while it is high.
REQ-007 The block SHALL have port tx_serial, output, 1: UART line, idle high.
REQ-008 The block SHALL have port tx_done, output, 1: one-cycle pulse marking the end of a frame.

Function
REQ-009 The block SHALL implement states IDLE, START, DATA, PARITY and STOP; PARITY exists only when the parity feature is compiled in.
REQ-010 In IDLE, byte_ready=1 at a clock edge SHALL accept a request: latch loadData[7:0] into the shift register, enter START, and set tx_busy=1 and tx_serial=0 on that same edge.
REQ-011 byte_ready SHALL be ignored in every state other than IDLE; the latched byte SHALL NOT change mid-frame when loadData changes.
REQ-012 A baud counter SHALL count 0..CLKS_PER_BIT-1; each bit SHALL be held on tx_serial for exactly CLKS_PER_BIT cycles, and the counter SHALL reset to 0 on every bit transition.
REQ-013 DATA SHALL send 8 bits LSB first, with a 3-bit index running 0..7; on index 7 at counter terminal count the block SHALL leave DATA.
REQ-014 STOP SHALL drive tx_serial=1 for CLKS_PER_BIT cycles.
REQ-015 On the edge ending STOP, the block SHALL return to IDLE, set tx_busy=0, and pulse tx_done=1 for exactly one cycle.
REQ-016 Frame length SHALL be 10*CLKS_PER_BIT cycles from the acceptance edge to the tx_busy fall (11*CLKS_PER_BIT with parity).
REQ-017 Back-to-back operation: byte_ready=1 on the first cycle with tx_busy=0 SHALL start the next frame with no extra idle bit beyond STOP.
REQ-018 All outputs SHALL be registered; tx_serial SHALL NOT glitch within a bit period.

Reset
REQ-019 When reset_n=0 at a clock edge, the block SHALL set state=IDLE, tx_serial=1, tx_busy=0, tx_done=0, baud counter=0, bit index=0 and shift register=0.
REQ-020 Reset asserted mid-frame SHALL abort the frame at that edge, return tx_serial high immediately, and SHALL NOT produce tx_done.
REQ-021 A request presented in the same cycle as reset_n=0 SHALL be discarded.

Configuration
REQ-022 With macro UART_TX_PARITY_EN defined, the block SHALL insert PARITY after DATA, sending one even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles before STOP.
REQ-023 Without UART_TX_PARITY_EN, DATA SHALL go directly to STOP, and no parity logic SHALL be synthesised.

Verification
REQ-024 With CLKS_PER_BIT=4 and loadData=32'hDEAD_BEA5, pulse byte_ready for 1 cycle -> tx_serial shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles; tx_busy is high for 40 cycles; tx_done is high for 1 cycle.
REQ-025 Hold byte_ready=1 continuously with loadData=32'h55 and then 32'hAA -> two consecutive 40-cycle frames separated by exactly one IDLE-acceptance edge; the second frame carries 8'hAA.
REQ-026 Change loadData from 32'h0F to 32'hF0 during DATA -> the transmitted bits remain 8'h0F.
REQ-027 Assert reset_n=0 during bit 3 of a frame -> on the next edge tx_serial=1, tx_busy=0, no tx_done pulse; a later request transmits correctly.
REQ-028 With UART_TX_PARITY_EN defined and CLKS_PER_BIT=4: byte 8'h07 -> parity bit 1 and frame length 44 cycles; byte 8'h03 -> parity bit 0.
REQ-029 Pulse byte_ready while tx_busy=1 -> no effect on the frame in progress; no second frame is started.
